sr_pulse_driver: RTL and testbench
==================================

Name: sr_pulse_driver

Overview:
- Upstream driver stage for the sr_latch block.
- Takes two asynchronous, bouncy raw inputs: set and reset push-buttons.
- Produces clean, synchronous, mutually exclusive S and R pulses that feed the latch's S and R inputs.
- The latch never sees S=R=1. A guaranteed hold cycle (S=R=0) separates any two pulses.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronized cycles an input must differ from its debounced level before that level flips. Legal range is 2..65535.
- PULSE_LEN, 1: width of each S/R pulse in clk cycles. Legal range is 1..255.
- RESET_PRIORITY, 1: when set and reset edges occur in the same cycle, 1 means R issues first and 0 means S issues first.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- set_raw  input  1  raw set button; asynchronous to clk.
- reset_raw  input  1  raw reset button; asynchronous to clk.
- S  output  1  registered set pulse to the latch.
- R  output  1  registered reset pulse to the latch.
- busy  output  1  high in SET_P, RST_P or GAP state.
- set_level  output  1  debounced level of set_raw.
- reset_level  output  1  debounced level of reset_raw.

Behaviour:
- Reset (rst_n low, async):
  - S=0, R=0, busy=0, set_level=0, reset_level=0.
  - Synchronizer flops, debounce counters, edge-detect delay flops and pending flags all cleared.
  - State=IDLE.
- Reset mid-pulse: S/R drop immediately and asynchronously. After rst_n deasserts, no pulse is reissued.
- Synchronizer: each raw input passes through 2 flops; sync value is the second flop.
- Debounce, per channel:
  - Counter width is ceil(log2(DEBOUNCE_CYCLES)).
  - If sync == level, the counter clears.
  - Otherwise the counter increments. When the counter == DEBOUNCE_CYCLES-1 and sync still differs, level <= sync and the counter clears.
  - Any bounce back to level before then clears the counter.
- Edge detect: rise = level & ~level_d (level_d is a registered copy of level). Only rising edges generate pulses; falling edges are ignored.
- Pending flags, one per channel:
  - Set by rise. Cleared when that channel's pulse starts.
  - Repeat rises while pending merge into the one request; there is no queue depth beyond 1.
- FSM states: IDLE, SET_P, RST_P, GAP.
  - IDLE:
    - Only set pending (or set rise this cycle): go to SET_P.
    - Only reset pending: go to RST_P.
    - Both pending: go to RST_P if RESET_PRIORITY=1, else SET_P; the loser stays pending.
  - SET_P: S=1 for PULSE_LEN cycles, then GAP.
  - RST_P: R=1 for PULSE_LEN cycles, then GAP.
  - GAP: exactly 1 cycle with S=R=0, then IDLE. The IDLE decision happens in the same edge as the GAP exit, so back-to-back pulses are separated by exactly one low cycle.
- S and R are flop outputs decoded from the registered state. S&R is never 1 in any cycle, including around reset.
- Latency:
  - If raw is at its new value and stable from clk edge k, then level flips at edge k+DEBOUNCE_CYCLES+1.
  - S/R rise at edge k+DEBOUNCE_CYCLES+2, provided the FSM is IDLE.
  - If the FSM is busy, the pulse starts at the first IDLE-exit after the current GAP.
- Button held indefinitely: exactly one pulse. Release then re-press (each debounced) gives another pulse.
- Both buttons held together: exactly one S and one R pulse, in priority order, separated by GAP.

Test Plan:
- Reset: rst_n=0 asserted mid-S-pulse (PULSE_LEN=3, reset at 2nd pulse cycle) -> S falls within the same cycle with no clk edge, all outputs 0. After release with inputs idle, no pulse for 20 cycles.
- Clean set press (DEBOUNCE_CYCLES=4, PULSE_LEN=1): set_raw 0->1 sampled at edge 0 and held -> set_level=1 at edge 5, S=1 for exactly edge 6..7, R stays 0. Holding for 100 cycles gives no further S.
- Bounce rejection: set_raw toggles 1,0,1,0 every 2 cycles then settles high at edge 10 -> exactly one S pulse, rising at edge 16. set_level never glitches.
- Simultaneous press, RESET_PRIORITY=1, PULSE_LEN=2: both raw rise at edge 0 -> R=1 at edges 6-7, GAP at edge 8, S=1 at edges 9-10. S&R never both 1.
- Simultaneous press with RESET_PRIORITY=0 -> same timing with S first, R second.
- Press during pulse: reset_raw rises while S pulse (PULSE_LEN=3) active, plus a second reset bounce while pending -> exactly one R pulse, starting the cycle after GAP. busy stays high continuously from S start to R end.

Source files
------------

// File: rtl/sr_pulse_driver.sv
// Debounced set/reset buttons -> mutually exclusive, gapped S/R pulses for the sr_latch.
// Latency: stable raw at edge k -> level at k+DEBOUNCE_CYCLES+1, pulse at k+DEBOUNCE_CYCLES+2; no backpressure, one request held per channel.
module sr_pulse_driver #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_LEN       = 1,
  parameter bit          RESET_PRIORITY  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_raw,
  input  logic reset_raw,
  output logic S,
  output logic R,
  output logic busy,
  output logic set_level,
  output logic reset_level
);

  localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]      PL_LAST = 8'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    RST_P = 2'd2,
    GAP   = 2'd3
  } state_e;

  // Channel index 0 is set, 1 is reset throughout.
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    lvl_q, lvl_d;
  logic [1:0]    lvl_dly_q, lvl_dly_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0]    rise;
  logic [1:0]    req;
  logic [1:0]    pend_q, pend_d;
  logic          pick_set, pick_rst;
  logic          start_set, start_rst;
  state_e        state_q, state_d;
  logic [7:0]    plen_q, plen_d;
  logic          s_q, s_d;
  logic          r_q, r_d;

  assign raw = {reset_raw, set_raw};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          lvl_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    lvl_dly_d = lvl_q;
  end

  assign rise = lvl_q & ~lvl_dly_q;

  // A rise in the current cycle counts as a request so an idle FSM reacts without a pending-flag delay.
  assign req      = pend_q | rise;
  assign pick_rst = req[1] & (RESET_PRIORITY | ~req[0]);
  assign pick_set = req[0] & ~pick_rst;

  always_comb begin
    state_d   = state_q;
    plen_d    = plen_q;
    start_set = 1'b0;
    start_rst = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        plen_d = '0;
        if (pick_rst) begin
          state_d   = RST_P;
          start_rst = 1'b1;
        end else if (pick_set) begin
          state_d   = SET_P;
          start_set = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SET_P, RST_P: begin
        if (plen_q == PL_LAST) begin
          state_d = GAP;
          plen_d  = '0;
        end else begin
          plen_d = plen_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        plen_d  = '0;
      end
    endcase
    pend_d = req & ~{start_rst, start_set};
    s_d    = (state_d == SET_P);
    r_d    = (state_d == RST_P);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      lvl_q     <= '0;
      lvl_dly_q <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
      pend_q    <= '0;
      state_q   <= IDLE;
      plen_q    <= '0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_dly_d;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
      pend_q    <= pend_d;
      state_q   <= state_d;
      plen_q    <= plen_d;
      s_q       <= s_d;
      r_q       <= r_d;
    end
  end

  assign S           = s_q;
  assign R           = r_q;
  assign busy        = (state_q != IDLE);
  assign set_level   = lvl_q[0];
  assign reset_level = lvl_q[1];

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed bench for sr_pulse_driver across four parameterisations; edge e = the e-th rising edge after stimulus starts.
module tb_sr_pulse_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;

  // a: PL=1 RP=1   b: PL=2 RP=1   c: PL=2 RP=0   d: PL=3 RP=1
  logic rst_n_a = 1'b0, set_a = 1'b0, rr_a = 1'b0;
  logic rst_n_b = 1'b0, set_b = 1'b0, rr_b = 1'b0;
  logic rst_n_c = 1'b0, set_c = 1'b0, rr_c = 1'b0;
  logic rst_n_d = 1'b0, set_d = 1'b0, rr_d = 1'b0;
  logic s_a, r_a, busy_a, sl_a, rl_a;
  logic s_b, r_b, busy_b, sl_b, rl_b;
  logic s_c, r_c, busy_c, sl_c, rl_c;
  logic s_d, r_d, busy_d, sl_d, rl_d;

  sr_pulse_driver #(.DEBOUNCE_CYCLES(4), .PULSE_LEN(1), .RESET_PRIORITY(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n_a), .set_raw(set_a), .reset_raw(rr_a),
    .S(s_a), .R(r_a), .busy(busy_a), .set_level(sl_a), .reset_level(rl_a));
  sr_pulse_driver #(.DEBOUNCE_CYCLES(4), .PULSE_LEN(2), .RESET_PRIORITY(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n_b), .set_raw(set_b), .reset_raw(rr_b),
    .S(s_b), .R(r_b), .busy(busy_b), .set_level(sl_b), .reset_level(rl_b));
  sr_pulse_driver #(.DEBOUNCE_CYCLES(4), .PULSE_LEN(2), .RESET_PRIORITY(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n_c), .set_raw(set_c), .reset_raw(rr_c),
    .S(s_c), .R(r_c), .busy(busy_c), .set_level(sl_c), .reset_level(rl_c));
  sr_pulse_driver #(.DEBOUNCE_CYCLES(4), .PULSE_LEN(3), .RESET_PRIORITY(1'b1)) u_d (
    .clk(clk), .rst_n(rst_n_d), .set_raw(set_d), .reset_raw(rr_d),
    .S(s_d), .R(r_d), .busy(busy_d), .set_level(sl_d), .reset_level(rl_d));

  always @(negedge clk) begin
    if ((s_a & r_a) | (s_b & r_b) | (s_c & r_c) | (s_d & r_d)) overlap++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++; if ({s_a, r_a, busy_a, sl_a, rl_a} !== 5'b0) begin n_fail++; $display("FAIL reset_a: got %b want 00000", {s_a, r_a, busy_a, sl_a, rl_a}); end
    n_checks++; if ({s_b, r_b, busy_b, sl_b, rl_b} !== 5'b0) begin n_fail++; $display("FAIL reset_b: got %b want 00000", {s_b, r_b, busy_b, sl_b, rl_b}); end
    n_checks++; if ({s_c, r_c, busy_c, sl_c, rl_c} !== 5'b0) begin n_fail++; $display("FAIL reset_c: got %b want 00000", {s_c, r_c, busy_c, sl_c, rl_c}); end
    n_checks++; if ({s_d, r_d, busy_d, sl_d, rl_d} !== 5'b0) begin n_fail++; $display("FAIL reset_d: got %b want 00000", {s_d, r_d, busy_d, sl_d, rl_d}); end
    rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1; rst_n_d = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_pulse();
    int highs;
    set_d = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      tick();
      if (e >= 6) begin
        n_checks++; if (s_d !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_s edge %0d: got %b want 1", e, s_d); end
      end
    end
    #2 rst_n_d = 1'b0;
    #1;
    n_checks++; if ({s_d, r_d, busy_d, sl_d, rl_d} !== 5'b0) begin n_fail++; $display("FAIL midrst_async: got %b want 00000", {s_d, r_d, busy_d, sl_d, rl_d}); end
    set_d = 1'b0;
    tick();
    tick();
    rst_n_d = 1'b1;
    highs = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (s_d | r_d | busy_d) highs++;
    end
    n_checks++; if (highs !== 0) begin n_fail++; $display("FAIL midrst_no_reissue: got %0d active cycles want 0", highs); end
  endtask

  task automatic test_clean_press();
    int highs;
    set_a = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      tick();
      n_checks++; if (sl_a !== (e >= 5)) begin n_fail++; $display("FAIL clean_level edge %0d: got %b want %b", e, sl_a, (e >= 5)); end
      n_checks++; if (s_a !== (e == 6)) begin n_fail++; $display("FAIL clean_s edge %0d: got %b want %b", e, s_a, (e == 6)); end
      n_checks++; if (r_a !== 1'b0) begin n_fail++; $display("FAIL clean_r edge %0d: got %b want 0", e, r_a); end
    end
    highs = 0;
    for (int e = 0; e < 100; e++) begin
      tick();
      if (s_a | r_a) highs++;
    end
    n_checks++; if (highs !== 0) begin n_fail++; $display("FAIL clean_hold: got %0d pulse cycles want 0", highs); end
    set_a = 1'b0;
    for (int e = 0; e < 12; e++) tick();
    n_checks++; if ({sl_a, s_a, busy_a} !== 3'b0) begin n_fail++; $display("FAIL clean_release: got %b want 000", {sl_a, s_a, busy_a}); end
  endtask

  task automatic test_bounce();
    for (int e = 0; e <= 20; e++) begin
      if (e < 2)       set_a = 1'b1;
      else if (e < 4)  set_a = 1'b0;
      else if (e < 6)  set_a = 1'b1;
      else if (e < 10) set_a = 1'b0;
      else             set_a = 1'b1;
      tick();
      n_checks++; if (sl_a !== (e >= 15)) begin n_fail++; $display("FAIL bounce_level edge %0d: got %b want %b", e, sl_a, (e >= 15)); end
      n_checks++; if (s_a !== (e == 16)) begin n_fail++; $display("FAIL bounce_s edge %0d: got %b want %b", e, s_a, (e == 16)); end
    end
    set_a = 1'b0;
  endtask

  task automatic test_simul_rst_first();
    int ov0;
    ov0 = overlap;
    set_b = 1'b1; rr_b = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      tick();
      n_checks++; if (r_b !== (e == 6 || e == 7)) begin n_fail++; $display("FAIL simr_r edge %0d: got %b want %b", e, r_b, (e == 6 || e == 7)); end
      n_checks++; if (s_b !== (e == 9 || e == 10)) begin n_fail++; $display("FAIL simr_s edge %0d: got %b want %b", e, s_b, (e == 9 || e == 10)); end
      n_checks++; if (busy_b !== (e >= 6 && e <= 11)) begin n_fail++; $display("FAIL simr_busy edge %0d: got %b want %b", e, busy_b, (e >= 6 && e <= 11)); end
    end
    n_checks++; if (overlap !== ov0) begin n_fail++; $display("FAIL simr_overlap: got %0d S&R cycles want 0", overlap - ov0); end
  endtask

  task automatic test_simul_set_first();
    int ov0;
    ov0 = overlap;
    set_c = 1'b1; rr_c = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      tick();
      n_checks++; if (s_c !== (e == 6 || e == 7)) begin n_fail++; $display("FAIL sims_s edge %0d: got %b want %b", e, s_c, (e == 6 || e == 7)); end
      n_checks++; if (r_c !== (e == 9 || e == 10)) begin n_fail++; $display("FAIL sims_r edge %0d: got %b want %b", e, r_c, (e == 9 || e == 10)); end
      n_checks++; if (busy_c !== (e >= 6 && e <= 11)) begin n_fail++; $display("FAIL sims_busy edge %0d: got %b want %b", e, busy_c, (e >= 6 && e <= 11)); end
    end
    n_checks++; if (overlap !== ov0) begin n_fail++; $display("FAIL sims_overlap: got %0d S&R cycles want 0", overlap - ov0); end
  endtask

  task automatic test_press_during_pulse();
    int highs;
    set_d = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      rr_d = (e >= 1) && !(e == 7 || e == 8);
      tick();
      n_checks++; if (s_d !== (e >= 6 && e <= 8)) begin n_fail++; $display("FAIL busyp_s edge %0d: got %b want %b", e, s_d, (e >= 6 && e <= 8)); end
      n_checks++; if (r_d !== (e >= 10 && e <= 12)) begin n_fail++; $display("FAIL busyp_r edge %0d: got %b want %b", e, r_d, (e >= 10 && e <= 12)); end
      n_checks++; if (busy_d !== (e >= 6 && e <= 13)) begin n_fail++; $display("FAIL busyp_busy edge %0d: got %b want %b", e, busy_d, (e >= 6 && e <= 13)); end
      n_checks++; if (rl_d !== (e >= 6)) begin n_fail++; $display("FAIL busyp_rlevel edge %0d: got %b want %b", e, rl_d, (e >= 6)); end
    end
    highs = 0;
    for (int e = 0; e < 30; e++) begin
      tick();
      if (s_d | r_d) highs++;
    end
    n_checks++; if (highs !== 0) begin n_fail++; $display("FAIL busyp_held: got %0d pulse cycles want 0", highs); end
    set_d = 1'b0; rr_d = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_pulse();
    test_clean_press();
    test_bounce();
    test_simul_rst_first();
    test_simul_set_first();
    test_press_during_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
